// File: rtl/d_to_ex_skid_reg.sv
// d_to_ex_skid_reg: elastic decode->execute pipeline stage.
// Carries one opaque packed payload from decode to execute through a valid/ready
// handshake backed by a 2-entry skid buffer (main + skid), so in_ready is taken
// straight from a flop and never combinationally depends on out_ready.
// A flush (branch mispredict) kills every beat held or arriving in that cycle.
// Optional feature macro: D2EX_PERF_EN adds three saturating performance counters
// (stall/bubble/flush). Without it the counter ports are tied to zero.

module d_to_ex_skid_reg #(
  parameter int DATA_W        = 160,
  parameter int ZERO_ON_FLUSH = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit ZeroPayload = (ZERO_ON_FLUSH != 0);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_fire_in;
  logic              w_fire_out;
  logic              w_main_free;

  // Handshake qualifiers: the stage accepts whenever skid is empty.
  always_comb begin
    w_fire_in   = in_valid & ~r_skid_valid;
    w_fire_out  = r_main_valid & out_ready;
    w_main_free = ~r_main_valid | w_fire_out;
  end

  // Main/skid state: rst beats flush, flush beats normal flow; skid drains before new beats.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      if (ZeroPayload) begin
        r_main_data <= {DATA_W{1'b0}};
        r_skid_data <= {DATA_W{1'b0}};
      end
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Oldest beat sits in skid: promote it; no new beat can fire while skid is full.
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else begin
        // Empty or pass-through: main takes the incoming beat, or goes empty.
        r_main_valid <= w_fire_in;
        if (w_fire_in) begin
          r_main_data <= in_data;
        end
      end
    end else begin
      // Main is held by downstream: park an accepted beat in skid.
      if (w_fire_in) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= in_data;
      end
    end
  end

  // Outputs come straight from the state flops.
  always_comb begin
    in_ready  = ~r_skid_valid;
    out_valid = r_main_valid;
    out_data  = r_main_data;
    occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  end

`ifdef D2EX_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters; they hold at all-ones and clear only on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_bubble_cnt <= {CNT_W{1'b0}};
      r_flush_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (r_main_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!r_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
      if (flush && (occupancy != 2'd0) && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  // Expose the counter flops.
  always_comb begin
    stall_cnt  = r_stall_cnt;
    bubble_cnt = r_bubble_cnt;
    flush_cnt  = r_flush_cnt;
  end
`else
  // Counters compiled out: ports kept and tied off so the interface is unchanged.
  always_comb begin
    stall_cnt  = {CNT_W{1'b0}};
    bubble_cnt = {CNT_W{1'b0}};
    flush_cnt  = {CNT_W{1'b0}};
  end
`endif

endmodule

// File: tb/tb_d_to_ex_skid_reg.sv
// Directed self-checking bench for d_to_ex_skid_reg (DATA_W=16, ZERO_ON_FLUSH=1, CNT_W=4).
// Inputs are driven 1 time unit after each rising edge; outputs are checked at that point.

module tb_d_to_ex_skid_reg;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;

  int n_checks;
  int n_fail;

  d_to_ex_skid_reg #(
    .DATA_W       (DW),
    .ZERO_ON_FLUSH(1),
    .CNT_W        (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d, input logic [1:0] occ);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check_eq({tag, "_data"}, 32'(out_data), 32'(d));
    end
    check_eq({tag, "_occ"}, 32'(occupancy), 32'(occ));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    out_ready = 1'b0;
    flush     = 1'b0;

    // 1. Reset with in_valid high.
    step();
    step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    // 2. Streaming 1..8 with out_ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      check_eq("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      check_out("stream", 1'b1, 16'(i), 2'd1);
    end
    in_valid = 1'b0;
    step();
    check_out("stream_drain", 1'b0, 16'h0, 2'd0);

    // 3. Skid: A to main, B to skid, C refused, then A,B,C drain back-to-back.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00A0;
    step();
    check_out("skid_a", 1'b1, 16'h00A0, 2'd1);
    check_eq("skid_rdy_a", 32'(in_ready), 32'd1);
    in_data = 16'h00B0;
    step();
    check_out("skid_b", 1'b1, 16'h00A0, 2'd2);
    check_eq("skid_rdy_b", 32'(in_ready), 32'd0);
    in_data = 16'h00C0;
    step();
    check_out("skid_c_refused", 1'b1, 16'h00A0, 2'd2);
    check_eq("skid_rdy_c", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check_out("drain_b", 1'b1, 16'h00B0, 2'd1);
    check_eq("drain_rdy", 32'(in_ready), 32'd1);
    step();
    check_out("drain_c", 1'b1, 16'h00C0, 2'd1);
    in_valid = 1'b0;
    step();
    check_out("drain_empty", 1'b0, 16'h0, 2'd0);

    // 4. Flush with both entries full and an input beat present.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    check_eq("pre_flush_occ", 32'(occupancy), 32'd2);
    in_data = 16'h0033;
    flush   = 1'b1;
    step();
    check_out("flush_full", 1'b0, 16'h0, 2'd0);
    check_eq("flush_zero_data", 32'(out_data), 32'd0);
    flush     = 1'b0;
    in_data   = 16'h0055;
    out_ready = 1'b1;
    step();
    check_out("after_flush", 1'b1, 16'h0055, 2'd1);
    in_valid = 1'b0;
    step();
    check_out("after_flush_empty", 1'b0, 16'h0, 2'd0);

    // Flush while in_ready=1 drops the arriving beat as well.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0066;
    step();
    in_data = 16'h0077;
    flush   = 1'b1;
    check_eq("flush_rdy_shown", 32'(in_ready), 32'd1);
    step();
    check_out("flush_drop_in", 1'b0, 16'h0, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check_out("flush_no_replay", 1'b0, 16'h0, 2'd0);

    // 5. Bubbles 1,0,1 with out_ready high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0061;
    step();
    check_out("bub_1", 1'b1, 16'h0061, 2'd1);
    in_valid = 1'b0;
    in_data  = 16'h0062;
    step();
    check_out("bub_0", 1'b0, 16'h0, 2'd0);
    in_valid = 1'b1;
    in_data  = 16'h0063;
    step();
    check_out("bub_1b", 1'b1, 16'h0063, 2'd1);
    in_valid = 1'b0;
    step();
    check_out("bub_end", 1'b0, 16'h0, 2'd0);

    // 6. Performance counters.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("perf_rst_stall", 32'(stall_cnt), 32'd0);
    check_eq("perf_rst_bubble", 32'(bubble_cnt), 32'd0);
    check_eq("perf_rst_flush", 32'(flush_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0099;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
    end
`ifdef D2EX_PERF_EN
    check_eq("perf_bubble_1", 32'(bubble_cnt), 32'd1);
    check_eq("perf_stall_5", 32'(stall_cnt), 32'd5);
`else
    check_eq("perf_off_stall", 32'(stall_cnt), 32'd0);
`endif
    for (int i = 0; i < 15; i++) begin
      step();
    end
`ifdef D2EX_PERF_EN
    check_eq("perf_stall_sat", 32'(stall_cnt), 32'hF);
`else
    check_eq("perf_off_stall_sat", 32'(stall_cnt), 32'd0);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef D2EX_PERF_EN
    check_eq("perf_flush_1", 32'(flush_cnt), 32'd1);
    check_eq("perf_bubble_3", 32'(bubble_cnt), 32'd3);
    check_eq("perf_stall_hold", 32'(stall_cnt), 32'hF);
`else
    check_eq("perf_off_flush", 32'(flush_cnt), 32'd0);
    check_eq("perf_off_bubble", 32'(bubble_cnt), 32'd0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("perf_clr_stall", 32'(stall_cnt), 32'd0);
    check_eq("perf_clr_bubble", 32'(bubble_cnt), 32'd0);
    check_eq("perf_clr_flush", 32'(flush_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
